// File: rtl/contention_gen_pkg.sv
// Shared frame-timing constants for the 48K/128K video and contention logic.
package contention_gen_pkg;

    // Beam counters are 9 bits wide; every frame-timing total must fit.
    localparam int CNT_W = 9;

    // Default 48K/128K raster: 448 pixel clocks per line, 312 lines per frame.
    localparam int DEF_H_TOTAL = 448;
    localparam int DEF_V_TOTAL = 312;

    // Paper (bitmap) area and the ULA fetch rhythm that causes contention.
    localparam int PAPER_WIDTH  = 256;
    localparam int PAPER_LINES  = 192;
    localparam int CONT_PERIOD  = 16;
    localparam int CONT_PHASES  = 12;
    localparam int CONT_PHASE_W = $clog2(CONT_PERIOD);

    // Default placement of the contended window and of the frame interrupt.
    localparam int DEF_CONT_HSTART = 0;
    localparam int DEF_INT_LINE    = 248;
    localparam int DEF_INT_HSTART  = 0;
    localparam int DEF_INT_LEN     = 64;

    // True when the CPU page selected by A15:A14 shares the bus with the ULA:
    // page 1 (4000-7FFF) always, page 3 (C000-FFFF) only for odd 128K banks.
    function automatic logic addr_contended(input logic [1:0] page,
                                            input logic       bank_contended);
        return (page == 2'b01) || ((page == 2'b11) && bank_contended);
    endfunction

endpackage

// File: rtl/contention_gen_video_counters.sv
// Horizontal/vertical beam position counters shared by the contention stage
// and the pixel fetch logic.
module video_counters
    import contention_gen_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] hc_o,
    output logic [CNT_W-1:0] vc_o
);

    // A total beyond 511 cannot be represented by the 9-bit counters.
    if ((H_TOTAL > 511) || (V_TOTAL > 511) || (H_TOTAL < 1) || (V_TOTAL < 1)) begin : g_bad_total
        $error("video_counters: H_TOTAL/V_TOTAL must be in 1..511");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;

    // Next beam position: hc wraps at end of line and carries into vc.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (en_i) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
            end else begin
                hc_d = hc_q + CNT_W'(1);
            end
        end
    end

    // Beam position registers, cleared to the top-left of the frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc_o = hc_q;
    assign vc_o = vc_q;

endmodule

// File: rtl/contention_gen.sv
// Frame timing and ULA contention: derives the CPU stall request and the
// Z80 frame interrupt from the beam position so both stay locked to video.
module contention_gen
    import contention_gen_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int CONT_HSTART = DEF_CONT_HSTART,
    parameter int INT_LINE    = DEF_INT_LINE,
    parameter int INT_HSTART  = DEF_INT_HSTART,
    parameter int INT_LEN     = DEF_INT_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk7en,
    input  logic             clk35en,
    input  logic             cont_enable,
    input  logic [15:0]      cpu_addr,
    input  logic             mreq_n,
    input  logic             iorq_n,
    input  logic             bank_contended,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             CPUContention,
    output logic             int_n
);

    logic [CNT_W-1:0] hc_w;
    logic [CNT_W-1:0] vc_w;

    video_counters #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_counters (
        .clk_i(clk),
        .rst_i(rst),
        .en_i (clk7en),
        .hc_o (hc_w),
        .vc_o (vc_w)
    );

    assign hc = hc_w;
    assign vc = vc_w;

    // Only the page bits and A0 (ULA port select) take part in the decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[13:1];

    // Beam position relative to the start of the contended window; the
    // modular subtraction lets the window straddle the hc wrap point.
    logic [CNT_W-1:0]        cont_rel;
    logic [CONT_PHASE_W-1:0] phase;
    logic                    in_window;
    logic                    phase_contended;

    // Beam position relative to the start of the interrupt pulse.
    logic [CNT_W-1:0] int_rel;
    logic             in_int;

    // CPU requests that would collide with a ULA fetch.
    logic mem_rq;
    logic io_rq;

    // IORQ sampled at the CPU rate and held between CPU enables.
    logic ioq_s_q, ioq_s_d;

    logic cont_q, cont_d;
    logic int_n_q, int_n_d;

    // Window, phase and interrupt-range decode from the current beam position.
    always_comb begin
        cont_rel        = hc_w - CNT_W'(CONT_HSTART);
        phase           = cont_rel[CONT_PHASE_W-1:0];
        in_window       = (int'(vc_w) < PAPER_LINES) && (int'(cont_rel) < PAPER_WIDTH);
        phase_contended = int'(phase) < CONT_PHASES;
        int_rel         = hc_w - CNT_W'(INT_HSTART);
        in_int          = (vc_w == CNT_W'(INT_LINE)) && (int'(int_rel) < INT_LEN);
    end

    // Request decode: a contended address during the T1 address phase, or an
    // even (ULA) port with IORQ seen at the last CPU sampling instant.
    always_comb begin
        mem_rq = addr_contended(cpu_addr[15:14], bank_contended) && mreq_n;
        io_rq  = ioq_s_q && !cpu_addr[0];
    end

    // Next-state for the IORQ sampler and both registered outputs; everything
    // except the sampler holds while the pixel enable is low.
    always_comb begin
        ioq_s_d = ioq_s_q;
        cont_d  = cont_q;
        int_n_d = int_n_q;
        if (clk35en) begin
            ioq_s_d = !iorq_n;
        end
        if (clk7en) begin
            cont_d  = cont_enable && in_window && phase_contended && (mem_rq || io_rq);
            int_n_d = !in_int;
        end
    end

    // Output and sampler registers; reset cancels any pending interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ioq_s_q <= 1'b0;
            cont_q  <= 1'b0;
            int_n_q <= 1'b1;
        end else begin
            ioq_s_q <= ioq_s_d;
            cont_q  <= cont_d;
            int_n_q <= int_n_d;
        end
    end

    assign CPUContention = cont_q;
    assign int_n         = int_n_q;

endmodule

// File: tb/tb_contention_gen.sv
// Directed bench for contention_gen on a shortened raster (264 x 194) with the
// interrupt moved to line 4 so a whole frame plus a reset test stays short.
module tb_contention_gen;

    localparam int H    = 264;
    localparam int V    = 194;
    localparam int IL   = 4;
    localparam int ILEN = 64;
    localparam int W    = 20;

    localparam int M_IDLE   = 0;
    localparam int M_MEM4   = 1;
    localparam int M_MEM8   = 2;
    localparam int M_NOCONT = 3;
    localparam int M_BANK   = 4;
    localparam int M_IOFE   = 5;
    localparam int M_IOFF   = 6;
    localparam int M_GAP    = 7;
    localparam int M_DROP   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk7en;
    logic        clk35en;
    logic        cont_enable;
    logic [15:0] cpu_addr;
    logic        mreq_n;
    logic        iorq_n;
    logic        bank_contended;
    logic [8:0]  hc;
    logic [8:0]  vc;
    logic        CPUContention;
    logic        int_n;

    contention_gen #(
        .H_TOTAL    (H),
        .V_TOTAL    (V),
        .CONT_HSTART(0),
        .INT_LINE   (IL),
        .INT_HSTART (0),
        .INT_LEN    (ILEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk7en        (clk7en),
        .clk35en       (clk35en),
        .cont_enable   (cont_enable),
        .cpu_addr      (cpu_addr),
        .mreq_n        (mreq_n),
        .iorq_n        (iorq_n),
        .bank_contended(bank_contended),
        .hc            (hc),
        .vc            (vc),
        .CPUContention (CPUContention),
        .int_n         (int_n)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int errors      = 0;
    int checks      = 0;
    int cont_cnt    = 0;
    int int_low_cnt = 0;

    // Expected beam/output state after the most recent modelled edge
    int   mh, mv;
    logic m_cont, m_int, m_ioq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the queued expectation once per edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("hc", hc, mon_e[19:11]);
            check("vc", vc, mon_e[10:2]);
            check("cont", CPUContention, mon_e[1]);
            check("int_n", int_n, mon_e[0]);
            if (CPUContention === 1'b1) cont_cnt++;
            if (int_n === 1'b0) int_low_cnt++;
        end
    end

    // Bus pattern for one pixel position i of a line in a given test mode.
    task automatic set_inputs(input int mode, input int i);
        cpu_addr       = 16'h0000;
        mreq_n         = 1'b0;
        iorq_n         = 1'b1;
        bank_contended = 1'b0;
        cont_enable    = 1'b1;
        case (mode)
            M_MEM4, M_GAP: begin cpu_addr = 16'h4000; mreq_n = 1'b1; end
            M_MEM8:        begin cpu_addr = 16'h8000; mreq_n = 1'b1; end
            M_NOCONT:      begin cpu_addr = 16'h4000; mreq_n = 1'b1; cont_enable = 1'b0; end
            M_BANK:        begin cpu_addr = 16'hC000; mreq_n = 1'b1; bank_contended = (i < 100); end
            M_IOFE:        begin cpu_addr = 16'h00FE; mreq_n = 1'b1; iorq_n = !((i >= 32) && (i <= 35)); end
            M_IOFF:        begin cpu_addr = 16'h00FF; mreq_n = 1'b1; iorq_n = !((i >= 32) && (i <= 35)); end
            M_DROP:        begin cpu_addr = 16'h4000; mreq_n = 1'b1; cont_enable = (i < 50); end
            default: ;
        endcase
    endtask

    // Driver: one clock edge with the given pixel enable; pushes the expected
    // result of that edge. clk35en fires on odd pixel positions.
    task automatic step(input logic en);
        int   nh, nv;
        logic nc, ni, nq, mem, io;
        nh = mh; nv = mv; nc = m_cont; ni = m_int; nq = m_ioq;
        clk7en  = en;
        clk35en = en && ((mh % 2) == 1);
        mem = mreq_n && ((cpu_addr[15:14] == 2'b01) ||
                         ((cpu_addr[15:14] == 2'b11) && bank_contended));
        io  = m_ioq && !cpu_addr[0];
        if (en) begin
            nc = cont_enable && (mv < 192) && (mh < 256) && ((mh % 16) < 12) && (mem || io);
            ni = !((mv == IL) && (mh < ILEN));
            if (mh == H - 1) begin
                nh = 0;
                nv = (mv == V - 1) ? 0 : mv + 1;
            end else begin
                nh = mh + 1;
            end
        end
        if (clk35en) nq = !iorq_n;
        @(posedge clk);
        #1;
        clk7en  = 1'b0;
        clk35en = 1'b0;
        exp_q.push_back({9'(nh), 9'(nv), nc, ni});
        mh = nh; mv = nv; m_cont = nc; m_int = ni; m_ioq = nq;
    endtask

    // One full line; optional hand-computed counts of contention/INT cycles.
    task automatic run_line(input int mode, input int exp_cont, input int exp_int, input string name);
        @(negedge clk);
        #1;
        cont_cnt    = 0;
        int_low_cnt = 0;
        for (int i = 0; i < H; i++) begin
            set_inputs(mode, i);
            step(1'b1);
            if ((mode == M_GAP) && ((i % 7) == 3)) step(1'b0);
        end
        @(negedge clk);
        #1;
        if (exp_cont >= 0) check({name, "_cont_cnt"}, cont_cnt, exp_cont);
        if (exp_int >= 0) check({name, "_int_cnt"}, int_low_cnt, exp_int);
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; m_cont = 1'b0; m_int = 1'b1; m_ioq = 1'b0;
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    // Stimulus
    initial begin
        rst     = 1'b1;
        clk7en  = 1'b0;
        clk35en = 1'b0;
        set_inputs(M_IDLE, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_hc", hc, 0);
        check("reset_vc", vc, 0);
        check("reset_cont", CPUContention, 0);
        check("reset_int_n", int_n, 1);
        @(negedge clk);
        rst = 1'b0;

        // Frame 1: directed lines; counts are 12 of every 16 positions in 0..255
        for (int l = 0; l < V; l++) begin
            case (l)
                IL:      run_line(M_IDLE,   0,  ILEN, "int_pulse");
                10:      run_line(M_MEM4,   192, 0,   "mem_4000");
                11:      run_line(M_MEM8,   0,   0,   "mem_8000");
                12:      run_line(M_NOCONT, 0,   0,   "cont_disabled");
                13:      run_line(M_BANK,   76,  0,   "bank_c000");
                14:      run_line(M_IOFE,   4,   0,   "io_fe");
                15:      run_line(M_IOFF,   0,   0,   "io_ff");
                20:      run_line(M_GAP,    -1,  0,   "clk7en_gaps");
                21:      run_line(M_DROP,   38,  0,   "cont_drop");
                193:     run_line(M_MEM4,   0,   0,   "mem_border_line");
                default: run_line(M_IDLE,   0,   0,   "idle_line");
            endcase
        end
        check("frame_wrap_hc", hc, 0);
        check("frame_wrap_vc", vc, 0);

        // Frame 2: reset in the middle of the interrupt pulse
        for (int l = 0; l < IL; l++) run_line(M_IDLE, 0, 0, "pre_int_line");
        @(negedge clk);
        #1;
        set_inputs(M_IDLE, 0);
        for (int i = 0; i < 20; i++) step(1'b1);
        @(negedge clk);
        #1;
        check("int_low_before_rst", int_n, 0);
        check("hc_before_rst", hc, 20);
        check("vc_before_rst", vc, IL);
        rst = 1'b1;
        #1;
        check("rst_async_int_n", int_n, 1);
        check("rst_async_hc", hc, 0);
        check("rst_async_vc", vc, 0);
        check("rst_async_cont", CPUContention, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int l = 0; l < IL; l++) run_line(M_IDLE, 0, 0, "no_retrigger");
        run_line(M_IDLE, 0, ILEN, "int_after_rst");
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/contention_gen.md
Name: contention_gen

Overview:
- Frame-timing and ULA contention stage; consumes the 7 MHz pixel enable and the 3.5 MHz CPU enable from the clock-enable generator.
- Produces CPUContention, which gates the CPU clock enable, and the frame interrupt for the Z80.
- Owns the horizontal and vertical pixel counters, so contention and the interrupt stay phase-locked to video.

Parameters:
- H_TOTAL, 448, pixel clocks per line (224 T-states).
- V_TOTAL, 312, lines per frame.
- CONT_HSTART, 0, hc value where the contended window starts on a paper line.
- INT_LINE, 248, vc value on which INT asserts.
- INT_HSTART, 0, hc value on INT_LINE where INT asserts.
- INT_LEN, 64, INT low duration in pixel clocks (32 T-states).

Ports:
- clk  in  1  master 28 MHz clock.
- rst  in  1  asynchronous, active-high reset.
- clk7en  in  1  pixel clock enable; all counter and output updates are qualified by it.
- clk35en  in  1  CPU-rate enable; marks the sampling instant for IORQ.
- cont_enable  in  1  1 = 48K/128K contention, 0 = no contention (Pentagon-style timing).
- cpu_addr  in  16  Z80 address bus.
- mreq_n  in  1  Z80 MREQ.
- iorq_n  in  1  Z80 IORQ.
- bank_contended  in  1  page mapped at C000-FFFF is contended (128K odd banks).
- hc  out  9  horizontal pixel counter, 0..H_TOTAL-1.
- vc  out  9  vertical line counter, 0..V_TOTAL-1.
- CPUContention  out  1  registered stall request to the CPU clock-enable logic.
- int_n  out  1  registered Z80 INT, active low.

Behaviour:
- Reset, asynchronous: hc=0, vc=0, CPUContention=0, int_n=1, ioq_s=0. Release takes effect at the next clk edge.
- Counters advance only on clk edges with clk7en=1.
- hc wraps from H_TOTAL-1 to 0. On that wrap vc increments; vc wraps from V_TOTAL-1 to 0.
- Width rule: 9-bit counters with no overflow past the TOTAL values. If a TOTAL parameter exceeds 511, elaboration fails.
- Window:
  - win = (vc<192) && (hc-CONT_HSTART in 0..255), using 9-bit modular subtraction.
  - phase p = (hc-CONT_HSTART)[3:0].
  - Within win, raw contention holds for p in 0..11 (6 T-states stalled, 2 free, per 8 T-states).
- Contended address:
  - ca = cpu_addr[15:14]==01, or (cpu_addr[15:14]==11 && bank_contended).
- Requests:
  - mem_rq = ca && mreq_n==1. This is the T1 address phase before MREQ falls; internal cycles with a contended address also qualify.
  - io_rq = ioq_s && cpu_addr[0]==0.
  - ioq_s is a register loaded with !iorq_n on each clk35en. It holds between clk35en pulses.
- CPUContention is registered on clk7en: next = cont_enable && win && p<12 && (mem_rq || io_rq). Latency from an hc change to the output is 1 clk7en.
- The combinational path from cpu_addr/mreq_n to CPUContention is forbidden. The output must be a flop.
- Interrupt: int_n is registered on clk7en.
  - Driven low when vc==INT_LINE and hc is in [INT_HSTART, INT_HSTART+INT_LEN-1]; otherwise 1.
  - It is not retriggered within a frame and is independent of CPU activity and cont_enable.
- cont_enable deasserted mid-window: CPUContention drops at the next clk7en. The counters are unaffected.
- rst asserted mid-frame: the counters restart at 0,0 and any pending INT is cancelled (int_n=1 immediately, asynchronously).
- clk7en low: all outputs hold their value.

Decomposition:
- Shared package/include: H_TOTAL, V_TOTAL, and the 48K/128K timing constants (paper width 256, paper lines 192, contention period 16, contended-phase count 12).
- One natural sub-module: video_counters. It holds hc/vc with wrap logic and is reusable by the pixel fetch logic.
- Contention and INT decode remain in contention_gen.

Test Plan:
- Reset then free-run:
  - hc reaches 447 then 0 while vc increments by 1.
  - After 448*312 clk7en pulses, hc=0 and vc=0 again.
- Static mem_rq (cpu_addr=4000h, mreq_n=1, cont_enable=1) on vc=10:
  - CPUContention=1 for 12 of every 16 clk7en pulses, starting 1 clk7en after hc=0.
  - CPUContention=0 for hc>=256.
- Same stimulus with cpu_addr=8000h, or with vc=200, or with cont_enable=0 -> CPUContention stays 0 for a full frame.
- cpu_addr=C000h: with bank_contended=1 the 12/16 pattern appears; after bank_contended=0 it stops within 1 clk7en.
- IO access, port FEh (addr[0]=0, iorq_n low for 2 clk35en) inside the window -> contention asserted. Port FFh -> never asserted.
- Interrupt timing:
  - int_n falls 1 clk7en after vc=248/hc=0 and stays low for exactly 64 clk7en.
  - rst asserted mid-pulse forces int_n=1 immediately, with no further INT until the next frame's vc=248.
